instr_encoder_loader: RTL
=========================

# instr_encoder_loader

Sequential RV32I instruction encoder and program loader, the encoding counterpart of the single-cycle opcode decoder/control unit. It accepts instruction fields over a valid/ready stream and packs each into a 32-bit word for R, I-ALU, load, store or branch format. It writes each word into instruction memory at consecutive word addresses, then signals completion. It sits between the testbench/boot source and the instruction-memory write port of the single-cycle core.

## Interface
- ADDR_W, 32: instruction-memory byte-address width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session. Ignored unless idle.
- base_addr  in  ADDR_W  byte address of the first word. Bits [1:0] are forced to 0.
- count  in  16  number of instructions in the session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block accepts a bundle.
- in_fmt  in  3  format code: R, I, LOAD, STORE, BRANCH.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3.
- in_funct7  in  7  used for R format only.
- in_imm  in  13  signed immediate.
- imem_we  out  1  write strobe, one cycle per word.
- imem_addr  out  ADDR_W  byte address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  session active.
- done  out  1  one-cycle pulse at session end.
- err_count  out  16  instructions replaced by NOP in the current session.

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - On start with count≠0: latch base_addr and count, clear err_count, go to ACCEPT.
  - On start with count=0: go directly to DONE; no writes occur.
- ACCEPT: in_ready=1. On in_valid&&in_ready, register the encoded word and go to WRITE.
- WRITE: imem_we=1, with imem_addr=current address and imem_wdata=registered word.
  - Then address += 4, modulo 2^ADDR_W (wraps silently).
  - Remaining count −1. If it reaches 0, go to DONE; otherwise go to ACCEPT.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in ACCEPT, WRITE and DONE.
- Encodings, with opcodes R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011:
  - R: funct7|rs2|rs1|f3|rd|op
  - I/LOAD: imm[11:0]|rs1|f3|rd|op
  - STORE: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
- Error rule: the word becomes NOP 0x00000013 and err_count increments (saturating at 0xFFFF) if any of these holds:
  - in_fmt is illegal (5–7);
  - for I/LOAD/STORE, imm[12]≠imm[11] (out of signed 12-bit range);
  - for BRANCH, imm[0]=1.
- An errored word is still written and still consumes one count.
- Unused fields of a format are ignored.

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err_count=0, state IDLE.
- Reset mid-session aborts at once: imem_we drops asynchronously, and the partially loaded memory is left as is.
- Start to first in_ready: 1 cycle.
- Handshake in cycle N: imem_we in cycle N+1. Throughput is one word per 2 cycles.
- in_valid may stay high across cycles. Bundles are consumed only in ACCEPT.
- The upstream source must hold the bundle stable while in_valid=1 and in_ready=0.
- Last WRITE in cycle N: done in cycle N+1, IDLE in N+2; a new start is accepted from N+2.
- start during busy has no effect.
- All outputs are registered except in_ready, which is decoded from state.

## Structure
- Package instr_encoder_pkg holds:
  - format codes FMT_R=3'd0, FMT_I=3'd1, FMT_LOAD=3'd2, FMT_STORE=3'd3, FMT_BRANCH=3'd4;
  - the five 7-bit opcode constants;
  - NOP_WORD=32'h00000013;
  - the FSM state enum.
- Sub-module rv_field_encoder: purely combinational. Inputs are the fields; outputs are word[31:0] and err. The top holds the FSM, counters and output registers.

## Test plan
- count=3 at base 0x100 with add x3,x1,x2 / addi x5,x0,10 / lw x6,4(x2) → writes 0x002081B3@0x100, 0x00A00293@0x104, 0x00412303@0x108; done pulses; err_count=0.
- sw x6,8(x2) then beq x1,x2,−8 (imm=13'h1FF8) → 0x00612423, then 0xFE208CE3.
- Illegal fmt 3'd6, addi with imm=13'h0800, and beq with imm=13'd3 → three writes of 0x00000013; err_count=3.
- base_addr=0xFFFFFFFC, count=2 → writes at 0xFFFFFFFC then 0x00000000.
- in_valid held low for 5 cycles in ACCEPT → no imem_we. start asserted while busy → ignored. start with count=0 → done one cycle later and no writes.
- reset asserted in the cycle imem_we=1 → imem_we=0 immediately; all outputs at reset values; the next start works normally.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared constants and types for the RV32I instruction encoder/loader.
package instr_encoder_pkg;

    // Field-bundle format codes
    localparam logic [2:0] FMT_R      = 3'd0;
    localparam logic [2:0] FMT_I      = 3'd1;
    localparam logic [2:0] FMT_LOAD   = 3'd2;
    localparam logic [2:0] FMT_STORE  = 3'd3;
    localparam logic [2:0] FMT_BRANCH = 3'd4;

    // RV32I major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StWrite,
        StDone
    } state_t;

endpackage

// File: rtl/rv_field_encoder.sv
// Combinational packer: instruction fields -> 32-bit RV32I word, with NOP substitution
// on illegal format or unencodable immediate.
module rv_field_encoder
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        err
);

    logic [31:0] raw;
    logic        bad;

    // Pack per format and flag anything that cannot be represented
    always_comb begin
        raw = NOP_WORD;
        bad = 1'b0;
        case (fmt)
            FMT_R: begin
                raw = {funct7, rs2, rs1, funct3, rd, OP_R};
            end
            FMT_I: begin
                raw = {imm[11:0], rs1, funct3, rd, OP_I};
                bad = imm[12] ^ imm[11];
            end
            FMT_LOAD: begin
                raw = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                bad = imm[12] ^ imm[11];
            end
            FMT_STORE: begin
                raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                bad = imm[12] ^ imm[11];
            end
            FMT_BRANCH: begin
                raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
                // Branch offsets are multiples of 2; bit 0 has no slot in the word
                bad = imm[0];
            end
            default: begin
                bad = 1'b1;
            end
        endcase
        err  = bad;
        word = bad ? NOP_WORD : raw;
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Sequential program loader: accepts field bundles over valid/ready, encodes each and
// writes it to instruction memory at consecutive word addresses.
module instr_encoder_loader
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [12:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_count
);

    localparam logic [ADDR_W-1:0] WordMask = ~{{(ADDR_W-2){1'b0}}, 2'b11};
    localparam logic [ADDR_W-1:0] WordStep = {{(ADDR_W-3){1'b0}}, 3'b100};

    state_t      state;
    logic [15:0] remaining;
    logic [31:0] enc_word;
    logic        enc_err;

    rv_field_encoder u_enc (
        .fmt    (in_fmt),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .word   (enc_word),
        .err    (enc_err)
    );

    assign in_ready = (state == StAccept);

    // Session FSM; imem_addr doubles as the running write address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            remaining  <= 16'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= 16'd0;
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (count != 16'd0) begin
                            imem_addr <= base_addr & WordMask;
                            remaining <= count;
                            err_count <= 16'd0;
                            state     <= StAccept;
                        end else begin
                            done  <= 1'b1;
                            state <= StDone;
                        end
                    end
                end
                StAccept: begin
                    if (in_valid) begin
                        imem_we    <= 1'b1;
                        imem_wdata <= enc_word;
                        if (enc_err && (err_count != 16'hFFFF)) begin
                            err_count <= err_count + 16'd1;
                        end
                        state <= StWrite;
                    end
                end
                StWrite: begin
                    imem_we   <= 1'b0;
                    imem_addr <= imem_addr + WordStep;
                    remaining <= remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        state <= StAccept;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
